// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that oversamples the host pins in the clk domain and writes
// 3-bit pixels into the R/G/B frame RAMs through a shared write port.
module spi_frame_loader #(
  parameter int N           = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sck,
  input  logic         sdi,
  input  logic         cs_n,
  output logic         we,
  output logic [N-1:0] adr,
  output logic         r_wd,
  output logic         g_wd,
  output logic         b_wd,
  output logic         busy,
  output logic         frame_done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR_HI = 3'd2,
    ADDR_LO = 3'd3,
    DATA    = 3'd4,
    DISCARD = 3'd5
  } state_t;

  state_t state_r, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync_r, sdi_sync_r, cs_sync_r, vld_sync_r;
  logic sck_s, sdi_s, cs_s, vld_s;
  logic sck_prev_r, cs_prev_r, armed_r;
  logic sck_rise_s, cs_fall_s, cs_rise_s, byte_done_s;
  logic [7:0] byte_s;

  // The first seven bits of a byte; the eighth is taken straight from sdi_s.
  logic [6:0]   shift_r, shift_nxt;
  logic [2:0]   cnt_r, cnt_nxt;
  logic [7:0]   addr_hi_r, addr_hi_nxt;
  logic         pix_any_r, pix_any_nxt;
  logic         err_r, err_nxt;
  logic         we_r, we_nxt;
  logic [N-1:0] adr_r, adr_nxt;
  logic [2:0]   rgb_r, rgb_nxt;
  logic         frame_done_r, frame_done_nxt;

  // Input synchronizers; vld tracks which stages already hold post-reset samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_r <= '0;
      sdi_sync_r <= '0;
      cs_sync_r  <= '1;
      vld_sync_r <= '0;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      vld_sync_r <= {vld_sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sck_s = sck_sync_r[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_r[SYNC_STAGES-1];
  assign cs_s  = cs_sync_r[SYNC_STAGES-1];
  assign vld_s = vld_sync_r[SYNC_STAGES-1];

  // Edge history; armed_r blocks a start until cs_n has really been seen high after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_prev_r <= 1'b0;
      cs_prev_r  <= 1'b1;
      armed_r    <= 1'b0;
    end else begin
      sck_prev_r <= sck_s;
      cs_prev_r  <= cs_s;
      armed_r    <= armed_r | (vld_s & cs_s);
    end
  end

  assign sck_rise_s  = ~sck_prev_r & sck_s;
  assign cs_fall_s   = armed_r & cs_prev_r & ~cs_s;
  assign cs_rise_s   = ~cs_prev_r & cs_s;
  assign byte_done_s = sck_rise_s & ~cs_s & (cnt_r == 3'd7) & (state_r != IDLE);
  assign byte_s      = {shift_r, sdi_s};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) state_nxt = CMD;
        else           state_nxt = IDLE;
      end
      CMD, ADDR_HI, ADDR_LO, DATA, DISCARD: begin
        if (cs_rise_s) begin
          state_nxt = IDLE;
        end else if (byte_done_s) begin
          case (state_r)
            CMD: begin
              if (byte_s == 8'h01)      state_nxt = ADDR_HI;
              else if (byte_s == 8'h02) state_nxt = DATA;
              else                      state_nxt = DISCARD;
            end
            ADDR_HI: state_nxt = ADDR_LO;
            ADDR_LO: state_nxt = DATA;
            default: state_nxt = state_r;
          endcase
        end else begin
          state_nxt = state_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values; adr advances in the cycle after each write.
  always_comb begin
    shift_nxt      = shift_r;
    cnt_nxt        = cnt_r;
    addr_hi_nxt    = addr_hi_r;
    pix_any_nxt    = pix_any_r;
    err_nxt        = err_r;
    we_nxt         = 1'b0;
    rgb_nxt        = rgb_r;
    frame_done_nxt = 1'b0;
    if (we_r) adr_nxt = adr_r + N'(1);
    else      adr_nxt = adr_r;

    if (state_r == IDLE) begin
      if (cs_fall_s) begin
        cnt_nxt     = 3'd0;
        shift_nxt   = 7'd0;
        pix_any_nxt = 1'b0;
        err_nxt     = 1'b0;
      end else begin
        cnt_nxt = cnt_r;
      end
    end else begin
      frame_done_nxt = cs_rise_s & pix_any_r;
      if (!cs_rise_s && sck_rise_s && !cs_s) begin
        shift_nxt = byte_s[6:0];
        cnt_nxt   = cnt_r + 3'd1;
      end else begin
        cnt_nxt = cnt_r;
      end
      if (byte_done_s) begin
        case (state_r)
          CMD: begin
            if (byte_s == 8'h02)      adr_nxt = '0;
            else if (byte_s != 8'h01) err_nxt = 1'b1;
            else                      err_nxt = err_r;
          end
          ADDR_HI: addr_hi_nxt = byte_s;
          ADDR_LO: adr_nxt     = N'({addr_hi_r, byte_s});
          DATA: begin
            we_nxt      = 1'b1;
            rgb_nxt     = byte_s[2:0];
            pix_any_nxt = 1'b1;
          end
          default: err_nxt = err_r;
        endcase
      end else begin
        we_nxt = 1'b0;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r      <= 7'd0;
      cnt_r        <= 3'd0;
      addr_hi_r    <= 8'd0;
      pix_any_r    <= 1'b0;
      err_r        <= 1'b0;
      we_r         <= 1'b0;
      adr_r        <= '0;
      rgb_r        <= 3'd0;
      frame_done_r <= 1'b0;
    end else begin
      shift_r      <= shift_nxt;
      cnt_r        <= cnt_nxt;
      addr_hi_r    <= addr_hi_nxt;
      pix_any_r    <= pix_any_nxt;
      err_r        <= err_nxt;
      we_r         <= we_nxt;
      adr_r        <= adr_nxt;
      rgb_r        <= rgb_nxt;
      frame_done_r <= frame_done_nxt;
    end
  end

  assign we         = we_r;
  assign adr        = adr_r;
  assign r_wd       = rgb_r[2];
  assign g_wd       = rgb_r[1];
  assign b_wd       = rgb_r[0];
  assign busy       = (state_r != IDLE);
  assign frame_done = frame_done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench for spi_frame_loader: directed SPI transactions push expected
// writes and frame_done pulses; a monitor pops and compares on every DUT pulse.
module tb_spi_frame_loader;
  localparam int N = 10;

  logic clk = 1'b0;
  logic reset, sck, sdi, cs_n;
  logic we, r_wd, g_wd, b_wd, busy, frame_done, err;
  logic [N-1:0] adr;

  spi_frame_loader #(.N(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .we(we), .adr(adr), .r_wd(r_wd), .g_wd(g_wd), .b_wd(b_wd),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] adr;
    logic [2:0]   rgb;
  } wr_t;

  wr_t wq[$];
  int  fdq[$];
  int  total = 0;
  int  bad   = 0;
  int  half  = 20;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every we / frame_done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got adr=%0h rgb=%0b expected no write", adr, {r_wd, g_wd, b_wd});
      end else begin
        wr_t e;
        e = wq.pop_front();
        check("wr_adr", 32'(adr), 32'(e.adr));
        check("wr_rgb", 32'({r_wd, g_wd, b_wd}), 32'(e.rgb));
      end
    end
    if (frame_done === 1'b1) begin
      if (fdq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame_done: got pulse expected none");
      end else begin
        void'(fdq.pop_front());
        check("fd_err", 32'(err), 32'(0));
      end
    end
  end

  task automatic send_bit(input logic b);
    sdi = b;
    #(half);
    sck = 1'b1;
    #(half);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic push_pix(input logic [N-1:0] a, input logic [7:0] v);
    wr_t e;
    e.adr = a;
    e.rgb = v[2:0];
    wq.push_back(e);
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_wq_left"}, 32'(wq.size()), 32'(0));
    check({tag, "_fdq_left"}, 32'(fdq.size()), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pv;
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_we", 32'(we), 32'(0));
    check("rst_adr", 32'(adr), 32'(0));
    check("rst_rgb", 32'({r_wd, g_wd, b_wd}), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_fd", 32'(frame_done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    repeat (5) @(negedge clk);

    // Full frame with clk = 4x sck.
    cs_start();
    send_byte(8'h02);
    for (int i = 0; i < 1024; i++) begin
      pv = 8'(i % 8);
      push_pix(N'(i), pv);
      send_byte(pv);
    end
    fdq.push_back(1);
    cs_end();
    check("full_err", 32'(err), 32'(0));
    check("full_adr_wrapped", 32'(adr), 32'(0));
    drain_check("full");

    // Addressed write at 0x20F.
    half = 30;
    cs_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h0F);
    push_pix(N'('h20F), 8'h05); send_byte(8'h05);
    push_pix(N'('h210), 8'h03); send_byte(8'h03);
    fdq.push_back(1);
    cs_end();
    check("addr_adr_next", 32'(adr), 32'h211);
    drain_check("addr");

    // Address wrap from 0x3FF.
    cs_start();
    send_byte(8'h01); send_byte(8'h03); send_byte(8'hFF);
    push_pix(N'('h3FF), 8'h04); send_byte(8'h04);
    push_pix(N'('h000), 8'h02); send_byte(8'h02);
    push_pix(N'('h001), 8'h01); send_byte(8'h01);
    fdq.push_back(1);
    cs_end();
    drain_check("wrap");

    // Unknown command, then err clears at the next start.
    cs_start();
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(8'h07);
    repeat (2) @(negedge clk);
    check("bad_err_set", 32'(err), 32'(1));
    cs_end();
    check("bad_err_sticky", 32'(err), 32'(1));
    drain_check("bad");
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("bad_err_clear", 32'(err), 32'(0));
    check("bad_busy_new", 32'(busy), 32'(1));
    cs_end();
    drain_check("empty");

    // Abort in the middle of a pixel.
    cs_start();
    send_byte(8'h02);
    for (int i = 0; i < 5; i++) send_bit(1'(i % 2));
    repeat (2) @(negedge clk);
    check("abort_busy_on", 32'(busy), 32'(1));
    cs_end();
    drain_check("abort");

    // Reset asserted mid-pixel; later sck edges must not write.
    cs_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h07);
    push_pix(N'('h007), 8'h06); send_byte(8'h06);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rrst_we", 32'(we), 32'(0));
    check("rrst_adr", 32'(adr), 32'(0));
    check("rrst_rgb", 32'({r_wd, g_wd, b_wd}), 32'(0));
    check("rrst_busy", 32'(busy), 32'(0));
    check("rrst_fd", 32'(frame_done), 32'(0));
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    send_byte(8'h02);
    send_byte(8'h07);
    repeat (2) @(negedge clk);
    check("rrst_idle", 32'(busy), 32'(0));
    cs_end();
    drain_check("rrst");

    // Minimum clock margin: 16 white pixels.
    half = 20;
    cs_start();
    send_byte(8'h02);
    for (int i = 0; i < 16; i++) begin
      push_pix(N'(i), 8'h07);
      send_byte(8'h07);
    end
    fdq.push_back(1);
    cs_end();
    check("slow_adr_next", 32'(adr), 32'(16));
    drain_check("slow");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
